// File: rtl/dca_matrix_lsu_load_formatter.sv
// dca_matrix_lsu_load_formatter
//   Load-side data formatter of the DCA matrix LSU. Accepts one load
//   instruction, consumes LSU read-data rows, widens each element to a tensor
//   scalar (sign/zero extend, columns past num_col_m1 forced to zero) and
//   pushes tensor rows out through a 2-entry registered buffer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_valid/inst_ready         instruction handshake (ready while idle)
//   inst_num_row_m1/_num_col_m1   matrix shape, minus one
//   inst_is_signed                1 = sign-extend, 0 = zero-extend
//   rdata_valid/ready/row         LSU read-data row input
//   tensor_valid/ready/row/last   tensor row output, last marks final row
//   busy                          instruction in progress
//   done                          one-cycle pulse after the final tensor row
module dca_matrix_lsu_load_formatter #(
    parameter int MATRIX_NUM_COL   = 4,
    parameter int BW_LSU_ELEMENT   = 32,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int BW_DIM_M1        = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     inst_valid,
    output logic                                     inst_ready,
    input  logic [BW_DIM_M1-1:0]                     inst_num_row_m1,
    input  logic [BW_DIM_M1-1:0]                     inst_num_col_m1,
    input  logic                                     inst_is_signed,
    input  logic                                     rdata_valid,
    output logic                                     rdata_ready,
    input  logic [MATRIX_NUM_COL*BW_LSU_ELEMENT-1:0] rdata_row,
    output logic                                     tensor_valid,
    input  logic                                     tensor_ready,
    output logic [MATRIX_NUM_COL*BW_TENSOR_SCALAR-1:0] tensor_row,
    output logic                                     tensor_last,
    output logic                                     busy,
    output logic                                     done
);
    localparam int ROW_W = MATRIX_NUM_COL * BW_TENSOR_SCALAR;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [BW_DIM_M1-1:0] row_m1, col_m1;
    logic                 is_signed;
    // One extra bit so a full 2^BW_DIM_M1-row matrix does not wrap.
    logic [BW_DIM_M1:0]   in_cnt, out_cnt;

    logic [1:0][ROW_W-1:0] mem;
    logic [1:0]            last_mem;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    logic [ROW_W-1:0] fmt_row;
    logic inst_fire, wr_en, rd_en, all_in, in_last, out_last;

    assign inst_ready   = (state == IDLE);
    assign busy         = (state != IDLE);
    assign inst_fire    = inst_valid && inst_ready;
    assign all_in       = (in_cnt > {1'b0, row_m1});
    assign in_last      = (in_cnt == {1'b0, row_m1});
    assign out_last     = (out_cnt == {1'b0, row_m1});
    // Registered state and count only: no path from tensor_ready.
    assign rdata_ready  = (state == RUN) && (count < 2'd2) && !all_in;
    assign wr_en        = rdata_valid && rdata_ready;
    assign tensor_valid = (count != 2'd0);
    assign rd_en        = tensor_valid && tensor_ready;
    assign tensor_row   = mem[rd_ptr];
    assign tensor_last  = last_mem[rd_ptr];

    // Per-column widening; applied before the row enters the buffer.
    for (genvar i = 0; i < MATRIX_NUM_COL; i++) begin : g_col
        localparam int unsigned CI = i;
        logic [BW_LSU_ELEMENT-1:0]   elem;
        logic [BW_TENSOR_SCALAR-1:0] sext, zext;
        assign elem = rdata_row[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT];
        assign sext = BW_TENSOR_SCALAR'($signed(elem));
        assign zext = BW_TENSOR_SCALAR'(elem);
        assign fmt_row[BW_TENSOR_SCALAR*i +: BW_TENSOR_SCALAR] =
            (CI > 32'(col_m1)) ? '0 : (is_signed ? sext : zext);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (inst_valid) state_nxt = RUN;
            RUN: begin
                if (rd_en && out_last)      state_nxt = IDLE;
                else if (wr_en && in_last)  state_nxt = DRAIN;
            end
            DRAIN: if (rd_en && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_m1    <= '0;
            col_m1    <= '0;
            is_signed <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            mem       <= '0;
            last_mem  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            done <= rd_en && out_last && (state != IDLE);
            if (inst_fire) begin
                row_m1    <= inst_num_row_m1;
                col_m1    <= inst_num_col_m1;
                is_signed <= inst_is_signed;
                in_cnt    <= '0;
                out_cnt   <= '0;
            end
            if (wr_en) begin
                mem[wr_ptr]      <= fmt_row;
                last_mem[wr_ptr] <= in_last;
                wr_ptr           <= ~wr_ptr;
                in_cnt           <= in_cnt + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= out_cnt + 1'b1;
            end
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end
endmodule

// File: tb/tb_dca_matrix_lsu_load_formatter.sv
module tb_dca_matrix_lsu_load_formatter;
    localparam int NC = 4, BL = 16, BT = 32, BD = 8;
    localparam int BUDGET = 3000;

    logic clk = 1'b0, rst = 1'b1;
    logic inst_valid = 1'b0, inst_ready, inst_is_signed = 1'b0;
    logic [BD-1:0] inst_num_row_m1 = '0, inst_num_col_m1 = '0;
    logic rdata_valid = 1'b0, rdata_ready;
    logic [NC*BL-1:0] rdata_row = '0;
    logic tensor_valid, tensor_ready = 1'b0, tensor_last, busy, done;
    logic [NC*BT-1:0] tensor_row;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    dca_matrix_lsu_load_formatter #(
        .MATRIX_NUM_COL(NC), .BW_LSU_ELEMENT(BL),
        .BW_TENSOR_SCALAR(BT), .BW_DIM_M1(BD)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
        .inst_is_signed(inst_is_signed),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_row(rdata_row),
        .tensor_valid(tensor_valid), .tensor_ready(tensor_ready),
        .tensor_row(tensor_row), .tensor_last(tensor_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [NC*BT-1:0] got, input logic [NC*BT-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference widening: plain integer arithmetic on the element value.
    function automatic logic [BT-1:0] ref_scalar(input int unsigned e, input int col, input int cm1, input bit sg);
        longint v;
        if (col > cm1) return '0;
        v = e;
        if (sg && e >= 32768) v = v - 65536 + 64'h1_0000_0000;
        return BT'(v);
    endfunction

    // Runs one instruction from a negedge; returns at the negedge of the done cycle.
    // rv_mode: 0 random valid, 1 always valid. tr_mode: 0 always ready, 1 random, 2 stall 5 cycles.
    task automatic run_inst(input int rm1, input int cm1, input bit sg, input int rv_mode,
                            input int tr_mode, input bit fixed, input logic [BL-1:0] fval);
        logic [NC*BT:0] q[$];
        logic [NC*BT-1:0] exp_row;
        int unsigned e;
        int sent = 0, recv = 0, cyc = 0;
        int n = rm1 + 1;
        chk("inst_ready_idle", inst_ready, 1);
        inst_valid = 1'b1;
        inst_num_row_m1 = BD'(rm1);
        inst_num_col_m1 = BD'(cm1);
        inst_is_signed = sg;
        @(posedge clk); @(negedge clk);
        inst_valid = 1'b0;
        inst_num_row_m1 = BD'($urandom);
        inst_num_col_m1 = BD'($urandom);
        inst_is_signed = 1'($urandom);
        while (recv < n && cyc < BUDGET) begin
            rdata_valid = (rv_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++)
                rdata_row[BL*i +: BL] = fixed ? fval : BL'($urandom);
            tensor_ready = (tr_mode == 0) ? 1'b1 :
                           (tr_mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 5);
            #1;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("rdata_ready", rdata_ready, (sent <= rm1) && (q.size() < 2));
            chk("tensor_valid", tensor_valid, q.size() != 0);
            if (tensor_valid && q.size() > 0) begin
                chk("tensor_row", tensor_row, q[0][NC*BT-1:0]);
                chk("tensor_last", tensor_last, q[0][NC*BT]);
            end
            if (rdata_valid && rdata_ready) begin
                for (int i = 0; i < NC; i++) begin
                    e = rdata_row[BL*i +: BL];
                    exp_row[BT*i +: BT] = ref_scalar(e, i, cm1, sg);
                end
                q.push_back({sent == rm1, exp_row});
                sent++;
            end
            if (tensor_valid && tensor_ready && q.size() > 0) begin
                void'(q.pop_front());
                recv++;
            end
            cyc++;
            @(posedge clk); @(negedge clk);
        end
        if (cyc >= BUDGET) chk("timeout", 1, 0);
        chk("rows_in", sent, n);
        rdata_valid = 1'b0;
        tensor_ready = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("inst_ready_done", inst_ready, 1);
        chk("busy_done", busy, 0);
        chk("tensor_valid_done", tensor_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_rdata_ready", rdata_ready, 0);
        chk("rst_tensor_valid", tensor_valid, 0);
        chk("rst_tensor_row", tensor_row, 0);
        chk("rst_tensor_last", tensor_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Basic unsigned, signed with mask, back-pressure, single row: back to back.
        run_inst(2, 3, 1'b0, 1, 0, 1'b1, 16'h8001);
        run_inst(3, 1, 1'b1, 1, 0, 1'b1, 16'hFFFE);
        run_inst(5, 3, 1'b1, 1, 2, 1'b0, '0);
        run_inst(0, 7, 1'b1, 1, 0, 1'b0, '0);
        chk("idle_after_single", busy, 0);

        // Reset with one row buffered.
        inst_valid = 1'b1; inst_num_row_m1 = 8'd3; inst_num_col_m1 = 8'd3; inst_is_signed = 1'b0;
        @(posedge clk); @(negedge clk);
        inst_valid = 1'b0;
        rdata_valid = 1'b1; rdata_row = 64'h1234_5678_9ABC_DEF0; tensor_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        rdata_valid = 1'b0;
        #1 chk("mid_buffered", tensor_valid, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        chk("mid_rst_tvalid", tensor_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_inst_ready", inst_ready, 1);
        rst = 1'b0;
        run_inst(3, 3, 1'b1, 0, 1, 1'b0, '0);

        // Full-size matrix: counter must not wrap.
        run_inst(255, 2, 1'b0, 1, 0, 1'b0, '0);

        for (int t = 0; t < 20; t++)
            run_inst($urandom_range(0, 9), $urandom_range(0, 7), 1'($urandom),
                     $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
